// File: rtl/rawp_port_arbiter.sv
// ---------------------------------------------------------------------------
// rawp_port_arbiter
//   Shares the single RAW port of wb_dma_ram between two on-chip masters
//   (r0, r1). Ownership is round-robin with bounded bursts. At most one
//   access (beat) is issued per cycle. Read data comes back a fixed one cycle
//   after the beat and is tagged to the requester that issued it.
//
// Ports
//   rawp_clk, rawp_rst          clock, asynchronous active-high reset
//   rN_req_i/adr_i/dat_i/we_i   requester N access request and payload
//   rN_gnt_o                    requester N owns the port this cycle
//   rN_rvalid_o, rN_err_o       completion pulse / out-of-range flag for
//                               the beat requester N issued last cycle
//   rdata_o                     shared read data, valid with rN_rvalid_o
//   ram_adr_o/dat_o/we_o        to the RAM RAW port
//   ram_dat_i, ram_stall_i      from the RAM RAW port
// ---------------------------------------------------------------------------
module rawp_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_BURST  = 8
) (
  input  logic                  rawp_clk,
  input  logic                  rawp_rst,
  input  logic                  r0_req_i,
  input  logic [ADDR_WIDTH-1:0] r0_adr_i,
  input  logic [31:0]           r0_dat_i,
  input  logic                  r0_we_i,
  input  logic                  r1_req_i,
  input  logic [ADDR_WIDTH-1:0] r1_adr_i,
  input  logic [31:0]           r1_dat_i,
  input  logic                  r1_we_i,
  output logic                  r0_gnt_o,
  output logic                  r1_gnt_o,
  output logic                  r0_rvalid_o,
  output logic                  r1_rvalid_o,
  output logic                  r0_err_o,
  output logic                  r1_err_o,
  output logic [31:0]           rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_adr_o,
  output logic [31:0]           ram_dat_o,
  output logic                  ram_we_o,
  input  logic [31:0]           ram_dat_i,
  input  logic                  ram_stall_i
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;     // index of the previous owner
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tag_vld_q, tag_vld_d;
  logic             tag_own_q, tag_own_d;

  logic own0, own1, beat, req_oth;
  logic [1:0] st_other;

  assign own0     = (state_q == ST_OWN0);
  assign own1     = (state_q == ST_OWN1);
  assign beat     = (own0 & r0_req_i) | (own1 & r1_req_i);
  assign req_oth  = own0 ? r1_req_i : r0_req_i;
  assign st_other = own0 ? ST_OWN1 : ST_OWN0;

  // Grants come straight from registered state: no req->gnt comb path.
  assign r0_gnt_o = own0;
  assign r1_gnt_o = own1;

  // RAM mux. Write enable only on a real beat so a granted-but-idle cycle
  // can never corrupt memory.
  always_comb begin
    ram_adr_o = '0;
    ram_dat_o = '0;
    ram_we_o  = 1'b0;
    if (own0) begin
      ram_adr_o = r0_adr_i;
      ram_dat_o = r0_dat_i;
      ram_we_o  = beat & r0_we_i;
    end else if (own1) begin
      ram_adr_o = r1_adr_i;
      ram_dat_o = r1_dat_i;
      ram_we_o  = beat & r1_we_i;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (r0_req_i && r1_req_i) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (r0_req_i)        state_d = ST_OWN0;
        else if (r1_req_i)        state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (beat) begin
          if (cnt_q == CNT_LAST) begin
            // Burst limit: hand over only if the other side is waiting,
            // otherwise the counter wraps and the owner keeps the port.
            cnt_d = '0;
            if (req_oth) state_d = st_other;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = req_oth ? st_other : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if ((state_d != state_q) && (state_q != ST_IDLE)) last_d = own1;
  end

  // Return tag captures the issuing owner so a hand-over in the same cycle
  // does not misroute the completion.
  assign tag_vld_d = beat;
  assign tag_own_d = own1;

  always_ff @(posedge rawp_clk or posedge rawp_rst) begin
    if (rawp_rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      tag_vld_q <= 1'b0;
      tag_own_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  assign r0_rvalid_o = tag_vld_q & ~tag_own_q;
  assign r1_rvalid_o = tag_vld_q &  tag_own_q;
  assign r0_err_o    = r0_rvalid_o & ram_stall_i;
  assign r1_err_o    = r1_rvalid_o & ram_stall_i;
  assign rdata_o     = ram_dat_i;

endmodule

// File: tb/tb_rawp_port_arbiter.sv
module tb_rawp_port_arbiter;
  localparam int AW = 11;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic [AW-1:0] r0_adr = '0, r1_adr = '0;
  logic [31:0]   r0_dat = '0, r1_dat = '0;
  logic          r0_we = 1'b0, r1_we = 1'b0;
  logic          r0_gnt, r1_gnt, r0_rv, r1_rv, r0_err, r1_err;
  logic [31:0]   rdata, ram_dat_o;
  logic [AW-1:0] ram_adr;
  logic          ram_we;
  logic [31:0]   ram_rd_q;
  logic          ram_st_q;

  rawp_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .rawp_clk(clk), .rawp_rst(rst),
    .r0_req_i(r0_req), .r0_adr_i(r0_adr), .r0_dat_i(r0_dat), .r0_we_i(r0_we),
    .r1_req_i(r1_req), .r1_adr_i(r1_adr), .r1_dat_i(r1_dat), .r1_we_i(r1_we),
    .r0_gnt_o(r0_gnt), .r1_gnt_o(r1_gnt),
    .r0_rvalid_o(r0_rv), .r1_rvalid_o(r1_rv),
    .r0_err_o(r0_err), .r1_err_o(r1_err),
    .rdata_o(rdata),
    .ram_adr_o(ram_adr), .ram_dat_o(ram_dat_o), .ram_we_o(ram_we),
    .ram_dat_i(ram_rd_q), .ram_stall_i(ram_st_q)
  );

  // RAM model: 512 words preloaded with their word index, synchronous
  // read, addresses >= 0x600 flagged out of range one cycle later.
  logic [31:0] mem [0:511];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 512; k++) mem[k] <= k;
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_adr[10:2]] <= ram_dat_o;
    end
    ram_rd_q <= mem[ram_adr[10:2]];
    ram_st_q <= (ram_adr >= 11'h600);
  end

  typedef struct packed { logic [AW-1:0] adr; logic [31:0] dat; logic we; } op_t;
  typedef struct packed { logic [31:0] dat; logic chk; logic err; } exp_t;

  op_t  q0[$], q1[$];
  exp_t e0[$], e1[$];
  int   beat_log[$];
  int   vec = 0, miss = 0;
  int   w0 = 0, w1 = 0, mw = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push0(input int adr, input logic [31:0] dat, input logic we,
                       input logic [31:0] edat, input logic echk, input logic eerr);
    q0.push_back('{adr: AW'(adr), dat: dat, we: we});
    e0.push_back('{dat: edat, chk: echk, err: eerr});
  endtask

  task automatic push1(input int adr, input logic [31:0] dat, input logic we,
                       input logic [31:0] edat, input logic echk, input logic eerr);
    q1.push_back('{adr: AW'(adr), dat: dat, we: we});
    e1.push_back('{dat: edat, chk: echk, err: eerr});
  endtask

  // Requester models: one beat consumed per cycle with gnt & req.
  initial begin
    logic b0, b1;
    forever begin
      @(negedge clk);
      b0 = !rst && r0_gnt && r0_req;
      b1 = !rst && r1_gnt && r1_req;
      @(posedge clk);
      if (b0 && q0.size() > 0) void'(q0.pop_front());
      if (b1 && q1.size() > 0) void'(q1.pop_front());
      #1;
      r0_req = (q0.size() > 0);
      r1_req = (q1.size() > 0);
      if (r0_req) begin r0_adr = q0[0].adr; r0_dat = q0[0].dat; r0_we = q0[0].we; end
      else begin r0_adr = '0; r0_dat = '0; r0_we = 1'b0; end
      if (r1_req) begin r1_adr = q1[0].adr; r1_dat = q1[0].dat; r1_we = q1[0].we; end
      else begin r1_adr = '0; r1_dat = '0; r1_we = 1'b0; end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (rst) begin
        w0 = 0; w1 = 0;
      end else begin
        if (r0_rv) begin
          vec++;
          if (e0.size() == 0) begin
            miss++; $display("FAIL rvalid0_unexpected: got 1 expected 0");
          end else begin
            ex = e0.pop_front();
            if ((ex.chk && rdata !== ex.dat) || r0_err !== ex.err) begin
              miss++;
              $display("FAIL ret0: got data %h err %b expected data %h err %b", rdata, r0_err, ex.dat, ex.err);
            end
          end
        end
        if (r1_rv) begin
          vec++;
          if (e1.size() == 0) begin
            miss++; $display("FAIL rvalid1_unexpected: got 1 expected 0");
          end else begin
            ex = e1.pop_front();
            if ((ex.chk && rdata !== ex.dat) || r1_err !== ex.err) begin
              miss++;
              $display("FAIL ret1: got data %h err %b expected data %h err %b", rdata, r1_err, ex.dat, ex.err);
            end
          end
        end
        if (r0_gnt && r0_req) beat_log.push_back(0);
        if (r1_gnt && r1_req) beat_log.push_back(1);
        if (r0_req && !r0_gnt) w0++; else w0 = 0;
        if (r1_req && !r1_gnt) w1++; else w1 = 0;
        if (w0 > mw) mw = w0;
        if (w1 > mw) mw = w1;
      end
    end
  end

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((q0.size() || q1.size() || e0.size() || e1.size()) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (n < limit), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, drops;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, drops;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt0", r0_gnt, 0);
    chk("rst_gnt1", r1_gnt, 0);
    chk("rst_rv0", r0_rv, 0);
    chk("rst_rv1", r1_rv, 0);
    chk("rst_err", {r0_err, r1_err}, 0);
    chk("rst_we", ram_we, 0);
    rst = 1'b0;

    // 1: r0 reads four words, grant one clock after req
    @(negedge clk);
    for (int i = 0; i < 4; i++) push0(4 * i, 0, 1'b0, i, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_req", r0_req, 1);
    chk("t1_gnt_lat0", r0_gnt, 0);
    @(negedge clk);
    chk("t1_gnt_lat1", r0_gnt, 1);
    wait_idle(50);

    // 2: write then read same address back-to-back
    push0(12'h010, 32'hDEADBEEF, 1'b1, 0, 1'b0, 1'b0);
    push0(12'h010, 0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    wait_idle(50);

    // 3: both from reset; 8-beat alternation starting with r0
    do_reset();
    beat_log.delete();
    for (int i = 0; i < 16; i++) begin
      push0(4 * (64 + i), 0, 1'b0, 64 + i, 1'b1, 1'b0);
      push1(4 * (128 + i), 0, 1'b0, 128 + i, 1'b1, 1'b0);
    end
    wait_idle(200);
    chk("t3_beats", beat_log.size(), 32);
    for (int i = 0; i < 32 && i < beat_log.size(); i++)
      chk("t3_owner", beat_log[i], (i / 8) % 2);
    chk("t3_maxwait", (mw <= MB + 1), 1);

    // 4: r0 alone for 20 beats keeps the port across burst boundaries
    for (int i = 0; i < 20; i++) push0(4 * (32 + i), 0, 1'b0, 32 + i, 1'b1, 1'b0);
    n = 0;
    while (!r0_gnt && n < 10) begin @(negedge clk); n++; end
    chk("t4_gnt_seen", (n < 10), 1);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(r0_gnt && r0_req)) drops++;
      if (i < 19) @(negedge clk);
    end
    chk("t4_no_drop", drops, 0);
    wait_idle(50);

    // out-of-range address raises err on the return
    push1(12'h7F0, 0, 1'b0, 32'h1FC, 1'b1, 1'b1);
    push1(12'h5FC, 0, 1'b0, 32'h17F, 1'b1, 1'b0);
    wait_idle(50);

    // 5: r0 drops req mid-ownership while r1 waits
    for (int i = 0; i < 3; i++) push0(12'h020 + 4 * i, 32'hAAAA0001 + i, 1'b1, 0, 1'b0, 1'b0);
    @(negedge clk);
    push1(12'h020, 0, 1'b0, 32'hAAAA0001, 1'b1, 1'b0);
    push1(12'h024, 0, 1'b0, 32'hAAAA0002, 1'b1, 1'b0);
    n = 0;
    while (q0.size() > 0 && n < 20) begin @(negedge clk); n++; end
    chk("t5_idle_gnt0", r0_gnt, 1);
    chk("t5_idle_req0", r0_req, 0);
    chk("t5_idle_we", ram_we, 0);
    chk("t5_idle_gnt1", r1_gnt, 0);
    @(negedge clk);
    chk("t5_gnt1", r1_gnt, 1);
    wait_idle(50);

    // 6: reset between beat issue and its return
    for (int i = 0; i < 8; i++) push0(4 * (200 + i), 0, 1'b0, 200 + i, 1'b1, 1'b0);
    n = 0;
    while (!(r0_gnt && r0_req) && n < 10) begin @(negedge clk); n++; end
    chk("t6_gnt_seen", (n < 10), 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_gnt0_async", r0_gnt, 0);
    chk("t6_rv0_async", r0_rv, 0);
    chk("t6_gnt1_async", r1_gnt, 0);
    q0.delete();
    e0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_post_gnt0", r0_gnt, 0);
      chk("t6_post_rv0", r0_rv, 0);
    end
    chk("max_wait", (mw <= MB + 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
